// File: rtl/cordic_pkg.sv
// Shared latency, width and tag types for the
// two-requester pipelined adder slice.
package cordic_pkg;

  localparam int ADD_LAT = 5;
  localparam int DATA_W  = 16;

  typedef logic req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/adder_pipe.sv
// Fixed-latency wrapping adder/subtractor.
// Result appears LAT clocks after operands are presented.
module adder_pipe #(
  parameter int LAT = 5,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] res;
  logic [W-1:0] b_eff;
  logic [W-1:0] stg_q [LAT];

  // subtract is a + ~b + 1, all modulo 2^W
  always_comb begin
    b_eff = sub ? ~b : b;
    res   = a + b_eff + {{(W-1){1'b0}}, sub};
  end

  // result delay line, first stage captures the sum
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q[0] <= res;
      for (int i = 1; i < LAT; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign sum = stg_q[LAT-1];

endmodule

// File: rtl/adder_pipe_arb.sv
// Round-robin front end sharing one pipelined adder
// between two requesters, with a tag pipe routing results.
module adder_pipe_arb #(
  parameter int ADD_LAT = cordic_pkg::ADD_LAT,
  parameter int DATA_W  = cordic_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        inflight
);

  import cordic_pkg::tag_t;
  import cordic_pkg::req_id_t;

  localparam logic [2:0] LAT_CNT = 3'(ADD_LAT);

  logic              gnt0;
  logic              gnt1;
  logic              issue;
  req_id_t           prio_q;
  tag_t              tag_q [ADD_LAT];
  tag_t              tag_out;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_sub;

  // grant: lone requester wins, ties go to prio_q
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !hold) begin
      unique case ({req1_valid, req0_valid})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          if (prio_q) gnt1 = 1'b1;
          else        gnt0 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign issue      = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // winner's operands feed the adder, zeros when idle
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    if (gnt0) begin
      op_a   = req0_a;
      op_b   = req0_b;
      op_sub = req0_sub;
    end else if (gnt1) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_sub = req1_sub;
    end
  end

  adder_pipe #(
    .LAT (ADD_LAT),
    .W   (DATA_W)
  ) u_add (
    .clk   (clk),
    .reset (reset),
    .a     (op_a),
    .b     (op_b),
    .sub   (op_sub),
    .sum   (rsp_data)
  );

  // pointer flips to the loser after each grant
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (issue) begin
      prio_q <= ~gnt1;
    end
  end

  // tag pipe tracks who owns each adder stage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: issue, id: gnt1};
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[ADD_LAT-1];

  // occupancy: +1 on issue, -1 on return, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      unique case ({issue, tag_out.vld})
        2'b10: begin
          if (cnt_q != LAT_CNT) cnt_q <= cnt_q + 3'd1;
        end
        2'b01: begin
          if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign rsp0_valid = !reset && tag_out.vld && !tag_out.id;
  assign rsp1_valid = !reset && tag_out.vld && tag_out.id;
  assign inflight   = reset ? 3'd0 : cnt_q;

endmodule

// File: tb/tb_adder_pipe_arb.sv
// Bench for adder_pipe_arb: directed table, reset
// mid-flight sequence and a random scoreboard run.
module tb_adder_pipe_arb;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sub, req1_sub;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_data;
  logic [2:0]  inflight;

  always #5 clk = ~clk;

  adder_pipe_arb #(
    .ADD_LAT (LAT),
    .DATA_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .inflight   (inflight)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic        v0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        s0;
    logic        v1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        s1;
    logic        r0;
    logic        r1;
    logic        rv0;
    logic        rv1;
    logic [15:0] dat;
    logic [2:0]  inf;
  } vec_t;

  typedef struct {
    int          due;
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t pq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic last_g = 1'b1;
  vec_t tbl [29];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic h, logic v0, logic [15:0] a0, logic [15:0] b0,
    logic s0, logic v1, logic [15:0] a1, logic [15:0] b1,
    logic s1, logic r0, logic r1, logic rv0, logic rv1,
    logic [15:0] dat, logic [2:0] inf);
    vec_t v;
    v.rst = 1'b0; v.hold = h;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1;
    v.r0 = r0; v.r1 = r1; v.rv0 = rv0; v.rv1 = rv1;
    v.dat = dat; v.inf = inf;
    return v;
  endfunction

  function automatic vec_t idle(logic rv0, logic rv1,
                                logic [15:0] dat,
                                logic [2:0] inf);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
              0, 0, rv0, rv1, dat, inf);
  endfunction

  // both requesters: 0x0100+0x0011 and 0x0100-0x0011
  function automatic vec_t both(logic h, logic r0,
                                logic r1, logic rv0,
                                logic rv1, logic [15:0] dat,
                                logic [2:0] inf);
    return mk(h, 1, 16'h0100, 16'h0011, 0,
              1, 16'h0100, 16'h0011, 1,
              r0, r1, rv0, rv1, dat, inf);
  endfunction

  // reference: per-cycle expectations from the rules
  task automatic model(input vec_t d);
    exp_t e;
    int   g;
    if (d.rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_rsp1", rsp1_valid, 0);
      chk("rst_inflight", inflight, 0);
      pq.delete();
      last_g = 1'b1;
    end else begin
      chk("inflight", inflight, pq.size());
      if (pq.size() > 0 && pq[0].due == cyc) begin
        e = pq.pop_front();
        chk("rsp0_valid", rsp0_valid, e.id == 1'b0);
        chk("rsp1_valid", rsp1_valid, e.id == 1'b1);
        chk("rsp_data", rsp_data, e.data);
      end else begin
        chk("rsp0_idle", rsp0_valid, 0);
        chk("rsp1_idle", rsp1_valid, 0);
      end
      g = -1;
      if (!d.hold) begin
        if (d.v0 && d.v1) g = last_g ? 0 : 1;
        else if (d.v0) g = 0;
        else if (d.v1) g = 1;
      end
      chk("ready0", req0_ready, g == 0);
      chk("ready1", req1_ready, g == 1);
      if (g >= 0) begin
        last_g = (g == 1);
        e.due = cyc + LAT;
        e.id  = (g == 1);
        if (g == 0)
          e.data = d.s0 ? d.a0 - d.b0 : d.a0 + d.b0;
        else
          e.data = d.s1 ? d.a1 - d.b1 : d.a1 + d.b1;
        pq.push_back(e);
      end
    end
  endtask

  task automatic run_cycle(input vec_t d);
    @(posedge clk);
    #1;
    reset      = d.rst;
    hold       = d.hold;
    req0_valid = d.v0;
    req0_a     = d.a0;
    req0_b     = d.b0;
    req0_sub   = d.s0;
    req1_valid = d.v1;
    req1_a     = d.a1;
    req1_b     = d.b1;
    req1_sub   = d.s1;
    @(negedge clk);
    model(d);
    cyc++;
  endtask

  initial begin
    vec_t d;
    int   nrsp;

    reset = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;

    tbl[0]  = mk(0, 1, 16'h1234, 16'h0FF0, 0,
                 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 16'h0001, 16'h0002, 1,
                 0, 1, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 16'hFFFF, 16'h0001, 0,
                 0, 1, 0, 0, 0, 2);
    tbl[3]  = idle(0, 0, 0, 3);
    tbl[4]  = idle(0, 0, 0, 3);
    tbl[5]  = idle(1, 0, 16'h2224, 3);
    tbl[6]  = idle(0, 1, 16'hFFFF, 2);
    tbl[7]  = idle(0, 1, 16'h0000, 1);
    tbl[8]  = both(0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = both(0, 0, 1, 0, 0, 0, 1);
    tbl[10] = both(0, 1, 0, 0, 0, 0, 2);
    tbl[11] = both(0, 0, 1, 0, 0, 0, 3);
    tbl[12] = both(0, 1, 0, 0, 0, 0, 4);
    tbl[13] = both(0, 0, 1, 1, 0, 16'h0111, 5);
    tbl[14] = idle(0, 1, 16'h00EF, 5);
    tbl[15] = idle(1, 0, 16'h0111, 4);
    tbl[16] = idle(0, 1, 16'h00EF, 3);
    tbl[17] = idle(1, 0, 16'h0111, 2);
    tbl[18] = idle(0, 1, 16'h00EF, 1);
    tbl[19] = both(1, 0, 0, 0, 0, 0, 0);
    tbl[20] = both(1, 0, 0, 0, 0, 0, 0);
    tbl[21] = both(1, 0, 0, 0, 0, 0, 0);
    tbl[22] = both(0, 1, 0, 0, 0, 0, 0);
    tbl[23] = idle(0, 0, 0, 1);
    tbl[24] = idle(0, 0, 0, 1);
    tbl[25] = idle(0, 0, 0, 1);
    tbl[26] = idle(0, 0, 0, 1);
    tbl[27] = idle(1, 0, 16'h0111, 1);
    tbl[28] = idle(0, 0, 0, 0);

    d = idle(0, 0, 0, 0);
    d.rst = 1'b1;
    run_cycle(d);
    run_cycle(d);

    for (int i = 0; i < 29; i++) begin
      run_cycle(tbl[i]);
      chk($sformatf("t%0d_ready0", i), req0_ready, tbl[i].r0);
      chk($sformatf("t%0d_ready1", i), req1_ready, tbl[i].r1);
      chk($sformatf("t%0d_rsp0", i), rsp0_valid, tbl[i].rv0);
      chk($sformatf("t%0d_rsp1", i), rsp1_valid, tbl[i].rv1);
      chk($sformatf("t%0d_infl", i), inflight, tbl[i].inf);
      if (tbl[i].rv0 || tbl[i].rv1)
        chk($sformatf("t%0d_data", i), rsp_data, tbl[i].dat);
    end

    // three issues, reset two cycles later, none return
    for (int i = 0; i < 3; i++) begin
      d = mk(0, 1, 16'(i * 7 + 3), 16'h0101, 0,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_cycle(d);
    end
    run_cycle(idle(0, 0, 0, 0));
    d = idle(0, 0, 0, 0);
    d.rst = 1'b1;
    run_cycle(d);
    nrsp = 0;
    d = mk(0, 1, 16'h0042, 16'h0002, 1,
           0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(d);
    chk("post_rst_ready0", req0_ready, 1);
    nrsp += int'(rsp0_valid) + int'(rsp1_valid);
    for (int i = 0; i < 4; i++) begin
      run_cycle(idle(0, 0, 0, 0));
      nrsp += int'(rsp0_valid) + int'(rsp1_valid);
    end
    chk("post_rst_no_rsp", nrsp, 0);
    run_cycle(idle(0, 0, 0, 0));
    chk("post_rst_op_rsp0", rsp0_valid, 1);
    chk("post_rst_op_data", rsp_data, 16'h0040);

    // random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      d = idle(0, 0, 0, 0);
      d.rst  = ($urandom_range(0, 999) == 0);
      d.hold = ($urandom_range(0, 6) == 0);
      d.v0   = ($urandom_range(0, 3) != 0);
      d.v1   = ($urandom_range(0, 3) != 0);
      d.a0   = 16'($urandom);
      d.b0   = 16'($urandom);
      d.s0   = 1'($urandom);
      d.a1   = 16'($urandom);
      d.b1   = 16'($urandom);
      d.s1   = 1'($urandom);
      run_cycle(d);
      chk("one_rsp", int'(rsp0_valid && rsp1_valid), 0);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      run_cycle(idle(0, 0, 0, 0));
    end
    chk("drained_inflight", inflight, 0);
    chk("drained_queue", pq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_pipe_arb.md
ADDER_PIPE_ARB -- requirements
Module: adder_pipe_arb

Interface
REQ-001 Parameter ADD_LAT, default 5, SHALL give the adder issue-to-result latency in clocks.
REQ-002 Parameter DATA_W, default 16, SHALL give the operand/result width; only 16 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  SHALL flag an operation request from requester 0/1.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  16  SHALL carry the operands.
REQ-007 req0_sub / req1_sub  input  1  SHALL select a-b when 1, a+b when 0.
REQ-008 req0_ready / req1_ready  output  1  SHALL be the grant; a request is accepted when valid and ready are both 1.
REQ-009 hold  input  1  SHALL block all issue while 1.
REQ-010 rsp0_valid / rsp1_valid  output  1  SHALL flag the result for requester 0/1.
REQ-011 rsp_data  output  16  SHALL carry the result, shared by both requesters.
REQ-012 inflight  output  3  SHALL count operations issued but not yet returned (0..ADD_LAT).

Function
REQ-013 At most one request SHALL be granted per cycle; ready SHALL depend combinationally on valid, hold and the round-robin pointer.
REQ-014 With hold=0 and one requester valid, that requester SHALL be granted.
REQ-015 With both valid, the requester not granted most recently SHALL win, and the pointer SHALL update only on a grant.
REQ-016 With hold=1, both ready outputs SHALL be 0, and the pointer SHALL be unchanged.
REQ-017 A granted operation's operands and sub flag SHALL drive the adder in the grant cycle; with no grant, the adder SHALL be driven with zeros and sub=0.
REQ-018 Arithmetic SHALL wrap modulo 2^16: a+b, or a+~b+1 for subtract; there is no overflow flag.
REQ-019 A tag pipeline ADD_LAT deep (valid plus 1-bit id) SHALL track each issue.
REQ-020 Exactly ADD_LAT cycles after a grant, rsp<id>_valid SHALL be 1 for one cycle, with rsp_data equal to that operation's result.
REQ-021 Both rsp valids SHALL never be 1 in the same cycle.
REQ-022 rsp_data SHALL be don't-care when no rsp valid is asserted.
REQ-023 There is no response backpressure; the sustained rate SHALL be 1 operation per clock.
REQ-024 inflight SHALL be +1 on a grant and -1 on a response, unchanged when both happen in the same cycle, and saturating at ADD_LAT.
REQ-025 Back-to-back grants to the same requester SHALL return results in issue order.

Reset
REQ-026 While reset=1: ready=0, rsp valids=0, inflight=0, tag pipeline cleared, and the pointer favours requester 0 next.
REQ-027 Operations in flight when reset asserts SHALL be discarded: no rsp valid for any of them after reset, even though the adder emits data.
REQ-028 Requests SHALL be grantable in the first cycle after reset deasserts.

Structure
REQ-029 ADD_LAT, DATA_W and the requester-id type SHALL live in shared package cordic_pkg.
REQ-030 The block SHALL instantiate exactly one existing adder_pipe as its sub-module, sharing clk/reset, and SHALL add no extra datapath registers around it.
REQ-031 The tag pipeline, round-robin pointer and inflight counter SHALL be local registers.

Verification
REQ-032 Single op: reset, then req0 with a=0x1234, b=0x0FF0, sub=0 -> ready0 in the same cycle; 5 cycles later rsp0_valid=1, rsp_data=0x2224.
REQ-033 Subtract wrap: req1 with a=0x0001, b=0x0002, sub=1 -> rsp1_valid after 5 cycles, rsp_data=0xFFFF; req1 with a=0xFFFF, b=0x0001, sub=0 -> 0x0000.
REQ-034 Contention: both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses alternate with matching data; inflight reaches 5 and holds.
REQ-035 Hold: both valid, hold=1 for 3 cycles -> no ready and no responses 5 cycles later; the pointer is unchanged after release.
REQ-036 Reset mid-flight: issue 3 ops, assert reset 2 cycles later for 1 cycle -> no rsp valid in the following 5 cycles, inflight=0.
REQ-037 Random scoreboard: 10k cycles of random valid/hold/operands -> every accepted op returns exactly once, in order, to the correct requester, with the modulo-2^16 result.
